// File: rtl/interval_timer_ctrl_if.sv
// interval_timer_ctrl_if
//   Groups the job handshake, completion handshake and counter status
//   signals of the interval timer controller.
//   master : CPU-side config/consumer logic (drives the job and acknowledges completion)
//   slave  : the controller itself
// Signals
//   start_valid/start_ready      job request handshake
//   start_period[WIDTH]          ticks per expiry, 0 encodes 2^WIDTH
//   start_prescale[PRESCALE_W]   clk cycles per tick minus 1
//   start_mode                   0 one-shot, 1 periodic
//   stop                         abort current job
//   cnt_q, cnt_en, expire, busy  counter status
//   done_valid/done_ready        one-shot completion handshake
interface interval_timer_ctrl_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) ();
  logic                  start_valid;
  logic                  start_ready;
  logic [WIDTH-1:0]      start_period;
  logic [PRESCALE_W-1:0] start_prescale;
  logic                  start_mode;
  logic                  stop;
  logic [WIDTH-1:0]      cnt_q;
  logic                  cnt_en;
  logic                  expire;
  logic                  busy;
  logic                  done_valid;
  logic                  done_ready;

  modport master (
    output start_valid, start_period, start_prescale, start_mode, stop, done_ready,
    input  start_ready, cnt_q, cnt_en, expire, busy, done_valid
  );

  modport slave (
    input  start_valid, start_period, start_prescale, start_mode, stop, done_ready,
    output start_ready, cnt_q, cnt_en, expire, busy, done_valid
  );
endinterface

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl
//   Sequences a WIDTH-bit interval counter. A job (period, prescale, mode)
//   is accepted in IDLE; in RUN a prescaler gates counter ticks, the
//   terminal tick pulses expire and either re-arms (periodic) or moves to
//   DONE and raises done_valid until the consumer accepts it (one-shot).
// Ports
//   clk    in  clock, rising edge
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of interval_timer_ctrl_if (job, status, completion)
module interval_timer_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input logic                  clk,
  input logic                  reset,
  interval_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                state;
  state_t                next_state;

  logic [WIDTH-1:0]      period_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  mode_q;
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [WIDTH-1:0]      cnt_q;
  logic [WIDTH-1:0]      cnt_plus;
  logic                  cnt_en;
  logic                  expire;
  logic                  busy;
  logic                  done_valid;
  logic                  tick;
  logic                  terminal;

  assign bus.cnt_q      = cnt_q;
  assign bus.cnt_en     = cnt_en;
  assign bus.expire     = expire;
  assign bus.busy       = busy;
  assign bus.done_valid = done_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and decoded outputs. The terminal compare wraps at WIDTH
  // bits, so a period of 0 naturally means "terminal when cnt_q is all ones".
  always_comb begin
    next_state      = state;
    bus.start_ready = 1'b0;
    cnt_plus        = cnt_q + 1'b1;
    tick            = (state == RUN) && (presc_cnt == prescale_q);
    terminal        = (cnt_plus == period_q);
    case (state)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) next_state = RUN;
      end
      RUN: begin
        if (bus.stop)                         next_state = IDLE;
        else if (tick && terminal && !mode_q) next_state = DONE;
      end
      DONE: begin
        if (bus.stop || bus.done_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Job latch, prescaler, counter and registered status outputs.
  // stop is checked before the tick so an abort suppresses cnt_en/expire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      presc_cnt  <= '0;
      cnt_q      <= '0;
      cnt_en     <= 1'b0;
      expire     <= 1'b0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      cnt_en <= 1'b0;
      expire <= 1'b0;
      busy   <= (next_state == RUN) || (next_state == DONE);
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            period_q   <= bus.start_period;
            prescale_q <= bus.start_prescale;
            mode_q     <= bus.start_mode;
            presc_cnt  <= '0;
            cnt_q      <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            presc_cnt <= '0;
            cnt_q     <= '0;
          end else if (tick) begin
            presc_cnt <= '0;
            cnt_en    <= 1'b1;
            if (terminal) begin
              cnt_q  <= '0;
              expire <= 1'b1;
              if (!mode_q) done_valid <= 1'b1;
            end else begin
              cnt_q <= cnt_plus;
            end
          end else begin
            presc_cnt <= presc_cnt + 1'b1;
          end
        end
        DONE: begin
          cnt_q     <= '0;
          presc_cnt <= '0;
          if (bus.stop || bus.done_ready) done_valid <= 1'b0;
        end
        default: begin
          cnt_q      <= '0;
          presc_cnt  <= '0;
          done_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl
//   Directed self-checking bench for interval_timer_ctrl. Inputs change on
//   the falling edge; outputs are sampled on the falling edge that follows
//   the rising edge of interest. "Edge i" below is the i-th rising edge
//   after the one that accepts the job (the accept edge is edge 0).
module tb_interval_timer_ctrl;

  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 4;

  logic clk;
  logic reset;
  int   tests;
  int   failures;

  interval_timer_ctrl_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

  interval_timer_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Checks all status outputs at once against hand-computed values
  task automatic checkStatus(input string tag, input int cnt, input bit en, input bit exp,
                             input bit bsy, input bit dv, input bit rdy);
    checkOutput({tag, ".cnt_q"},       32'(bus.cnt_q),       32'(cnt));
    checkOutput({tag, ".cnt_en"},      32'(bus.cnt_en),      32'(en));
    checkOutput({tag, ".expire"},      32'(bus.expire),      32'(exp));
    checkOutput({tag, ".busy"},        32'(bus.busy),        32'(bsy));
    checkOutput({tag, ".done_valid"},  32'(bus.done_valid),  32'(dv));
    checkOutput({tag, ".start_ready"}, 32'(bus.start_ready), 32'(rdy));
  endtask

  task automatic applyStimulus(input bit valid, input int period, input int prescale,
                               input bit mode, input bit stp, input bit dready);
    bus.start_valid    = valid;
    bus.start_period   = WIDTH'(period);
    bus.start_prescale = PRESCALE_W'(prescale);
    bus.start_mode     = mode;
    bus.stop           = stp;
    bus.done_ready     = dready;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    reset    = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    step();
    checkStatus("reset", 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    step();
    checkStatus("idle", 0, 0, 0, 0, 0, 1);

    // stop in IDLE is ignored, and does not block an accept in the same cycle
    applyStimulus(0, 3, 0, 0, 1, 0);
    step();
    checkStatus("stop_idle", 0, 0, 0, 0, 0, 1);

    // One-shot, period 3, prescale 0: ticks at edges 1,2,3; terminal at 3
    applyStimulus(1, 3, 0, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkStatus("os.e0", 0, 0, 0, 1, 0, 0);
    step();
    checkStatus("os.e1", 1, 1, 0, 1, 0, 0);
    step();
    checkStatus("os.e2", 2, 1, 0, 1, 0, 0);
    step();
    checkStatus("os.e3", 0, 1, 1, 1, 1, 0);
    step();
    checkStatus("os.e4", 0, 0, 0, 1, 1, 0);
    step();
    checkStatus("os.e5", 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkStatus("os.ack", 0, 0, 0, 0, 0, 1);

    // Periodic, period 4, prescale 1: tick on even edges, expire every 8.
    // A second job with different inputs is offered mid-run and must be ignored.
    applyStimulus(1, 4, 1, 1, 0, 0);
    step();
    applyStimulus(0, 4, 1, 1, 0, 0);
    checkStatus("per.e0", 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) applyStimulus(1, 2, 0, 0, 0, 0);
      if (i == 6) applyStimulus(0, 7, 5, 0, 0, 0);
      step();
      checkStatus($sformatf("per.e%0d", i), (i / 2) % 4, (i % 2) == 0, (i % 8) == 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkStatus("per.stop", 0, 0, 0, 0, 0, 1);

    // Periodic, period 0 (=16), prescale 0: cnt_q wraps 15->0 on expire
    applyStimulus(1, 0, 0, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 33; i++) begin
      step();
      checkStatus($sformatf("p16.e%0d", i), i % 16, 1, (i % 16) == 0, 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkStatus("p16.stop", 0, 0, 0, 0, 0, 1);

    // Stop on the terminal tick (one-shot period 2, terminal at edge 2)
    applyStimulus(1, 2, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkStatus("stp.e1", 1, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkStatus("stp.e2", 0, 0, 0, 0, 0, 1);

    // Period 1 with prescale 2: first tick is terminal at edge 3; stop from DONE
    applyStimulus(1, 1, 2, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkStatus("p1.e1", 0, 0, 0, 1, 0, 0);
    step();
    checkStatus("p1.e2", 0, 0, 0, 1, 0, 0);
    step();
    checkStatus("p1.e3", 0, 1, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkStatus("p1.stop", 0, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-RUN with cnt_q=2
    applyStimulus(1, 5, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    step();
    checkStatus("rst.pre", 2, 1, 0, 1, 0, 0);
    reset = 1'b1;
    #1;
    checkStatus("rst.async", 0, 0, 0, 0, 0, 1);
    step();
    reset = 1'b0;
    step();
    checkStatus("rst.post", 0, 0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
